// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, constants and state encoding for the register-file
// write-port arbiter.
`default_nettype none

package rf_arb_pkg;

  localparam int REG_ID_W = 5;
  localparam int DATA_W   = 16;
  localparam int FLAG_W   = 8;

  localparam logic [REG_ID_W-1:0] NO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STEAL = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if: MEM-stage writeback, debug write request and
// register-file write port bundled for the arbiter.
`default_nettype none

interface rf_wport_arbiter_if;
  import rf_arb_pkg::*;

  logic [REG_ID_W-1:0] MEM_Wr_id;
  logic [DATA_W-1:0]   MEM_Result;
  logic [FLAG_W-1:0]   MEM_Fmask;
  logic [FLAG_W-1:0]   MEM_Flags;

  logic                dbg_req;
  logic [REG_ID_W-1:0] dbg_Wr_id;
  logic [DATA_W-1:0]   dbg_data;
  logic [FLAG_W-1:0]   dbg_Fmask;
  logic [FLAG_W-1:0]   dbg_Flags;
  logic                dbg_ack;

  logic                mem_hold;

  logic [REG_ID_W-1:0] RF_Wr_id;
  logic [DATA_W-1:0]   RF_Result;
  logic [FLAG_W-1:0]   RF_Fmask;
  logic [FLAG_W-1:0]   RF_Flags;

  // Arbiter side
  modport slave (
    input  MEM_Wr_id, MEM_Result, MEM_Fmask, MEM_Flags,
    input  dbg_req, dbg_Wr_id, dbg_data, dbg_Fmask, dbg_Flags,
    output dbg_ack, mem_hold,
    output RF_Wr_id, RF_Result, RF_Fmask, RF_Flags
  );

  // Pipeline / debug requester / register file side
  modport master (
    output MEM_Wr_id, MEM_Result, MEM_Fmask, MEM_Flags,
    output dbg_req, dbg_Wr_id, dbg_data, dbg_Fmask, dbg_Flags,
    input  dbg_ack, mem_hold,
    input  RF_Wr_id, RF_Result, RF_Fmask, RF_Flags
  );

endinterface

`default_nettype wire

// File: rtl/rf_wport_mux.sv
// rf_wport_mux: selects register fields and flag fields independently from
// the MEM or debug side.
`default_nettype none

module rf_wport_mux
  import rf_arb_pkg::*;
(
  input  logic                reg_from_dbg,
  input  logic                flg_from_dbg,
  input  logic [REG_ID_W-1:0] mem_wr_id,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic [FLAG_W-1:0]   mem_fmask,
  input  logic [FLAG_W-1:0]   mem_flags,
  input  logic [REG_ID_W-1:0] dbg_wr_id,
  input  logic [DATA_W-1:0]   dbg_data,
  input  logic [FLAG_W-1:0]   dbg_fmask,
  input  logic [FLAG_W-1:0]   dbg_flags,
  output logic [REG_ID_W-1:0] rf_wr_id,
  output logic [DATA_W-1:0]   rf_result,
  output logic [FLAG_W-1:0]   rf_fmask,
  output logic [FLAG_W-1:0]   rf_flags
);

  assign rf_wr_id  = reg_from_dbg ? dbg_wr_id : mem_wr_id;
  assign rf_result = reg_from_dbg ? dbg_data  : mem_result;
  assign rf_fmask  = flg_from_dbg ? dbg_fmask : mem_fmask;
  assign rf_flags  = flg_from_dbg ? dbg_flags : mem_flags;

endmodule

`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the register-file/flag write port between MEM
// writeback and a debug requester, stealing one MEM cycle on starvation.
`default_nettype none

module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  rf_wport_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  arb_state_t       state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt, cnt_inc;
  logic             hold_q;

  logic mem_reg, mem_flg, mem_valid, dbg_reg, dbg_flg;
  logic reg_sel, flg_sel, ack;

  assign mem_reg   = (bus.MEM_Wr_id != NO_REG);
  assign mem_flg   = (bus.MEM_Fmask != '0);
  assign mem_valid = mem_reg | mem_flg;
  assign dbg_reg   = (bus.dbg_Wr_id != NO_REG);
  assign dbg_flg   = (bus.dbg_Fmask != '0);

  // Grant decision; reset forces plain MEM pass-through with no ack.
  always_comb begin
    reg_sel = 1'b0;
    flg_sel = 1'b0;
    ack     = 1'b0;
    if (!RST) begin
      if (state == STEAL) begin
        reg_sel = 1'b1;
        flg_sel = 1'b1;
        ack     = 1'b1;
      end else if (bus.dbg_req) begin
        if (!mem_valid) begin
          reg_sel = 1'b1;
          flg_sel = 1'b1;
          ack     = 1'b1;
        end else if (!mem_reg && !dbg_flg) begin
          reg_sel = 1'b1;
          ack     = 1'b1;
        end else if (!mem_flg && !dbg_reg) begin
          flg_sel = 1'b1;
          ack     = 1'b1;
        end
      end
    end
  end

  // Counter value after this cycle = cycles already waited; the steal is
  // scheduled when that reaches MAX_WAIT-1 so the ack lands on cycle MAX_WAIT.
  assign cnt_inc = (state == IDLE) ? CNT_W'(1) : wait_cnt + CNT_W'(1);

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    case (state)
      IDLE, PEND: begin
        if (ack || !bus.dbg_req) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt_inc == LAST_WAIT) begin
          next_state = STEAL;
          next_cnt   = '0;
        end else begin
          next_state = PEND;
          next_cnt   = cnt_inc;
        end
      end
      STEAL: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      hold_q   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      hold_q   <= (next_state == STEAL);
    end
  end

  assign bus.dbg_ack  = ack;
  assign bus.mem_hold = hold_q;

  rf_wport_mux u_mux (
    .reg_from_dbg (reg_sel),
    .flg_from_dbg (flg_sel),
    .mem_wr_id    (bus.MEM_Wr_id),
    .mem_result   (bus.MEM_Result),
    .mem_fmask    (bus.MEM_Fmask),
    .mem_flags    (bus.MEM_Flags),
    .dbg_wr_id    (bus.dbg_Wr_id),
    .dbg_data     (bus.dbg_data),
    .dbg_fmask    (bus.dbg_Fmask),
    .dbg_flags    (bus.dbg_Flags),
    .rf_wr_id     (bus.RF_Wr_id),
    .rf_result    (bus.RF_Result),
    .rf_fmask     (bus.RF_Fmask),
    .rf_flags     (bus.RF_Flags)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: directed scoreboard bench for rf_wport_arbiter with
// MAX_WAIT=8.
`default_nettype none

module tb_rf_wport_arbiter;

  typedef struct {
    string       tag;
    logic        ack;
    logic        hold;
    logic [4:0]  id;
    logic [15:0] res;
    logic [7:0]  fm;
    logic [7:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.MAX_WAIT(8), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem(input logic [4:0] id, input logic [15:0] res,
                     input logic [7:0] fm, input logic [7:0] fl);
    bus.MEM_Wr_id  = id;
    bus.MEM_Result = res;
    bus.MEM_Fmask  = fm;
    bus.MEM_Flags  = fl;
  endtask

  task automatic dbg(input logic req, input logic [4:0] id, input logic [15:0] d,
                     input logic [7:0] fm, input logic [7:0] fl);
    bus.dbg_req   = req;
    bus.dbg_Wr_id = id;
    bus.dbg_data  = d;
    bus.dbg_Fmask = fm;
    bus.dbg_Flags = fl;
  endtask

  task automatic expect_out(input string tag, input logic ack, input logic hold,
                            input logic [4:0] id, input logic [15:0] res,
                            input logic [7:0] fm, input logic [7:0] fl);
    exp_t e;
    e.tag = tag; e.ack = ack; e.hold = hold;
    e.id = id; e.res = res; e.fm = fm; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".ack"},  32'(bus.dbg_ack),   32'(e.ack));
      chk({e.tag, ".hold"}, 32'(bus.mem_hold),  32'(e.hold));
      chk({e.tag, ".id"},   32'(bus.RF_Wr_id),  32'(e.id));
      chk({e.tag, ".res"},  32'(bus.RF_Result), 32'(e.res));
      chk({e.tag, ".fm"},   32'(bus.RF_Fmask),  32'(e.fm));
      chk({e.tag, ".fl"},   32'(bus.RF_Flags),  32'(e.fl));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: MEM passes through, pending debug request is not acked
    mem(5'd9, 16'hAAAA, 8'h03, 8'h02);
    dbg(1'b1, 5'd1, 16'h0101, 8'h00, 8'h00);
    expect_out("reset", 1'b0, 1'b0, 5'd9, 16'hAAAA, 8'h03, 8'h02);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dbg(1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    mem(5'd0, 16'h0, 8'h0, 8'h0);
    expect_out("post_reset_idle", 1'b0, 1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    cyc();

    // Free grant on idle MEM cycle
    dbg(1'b1, 5'd5, 16'hBEEF, 8'h00, 8'h00);
    expect_out("idle_grant", 1'b1, 1'b0, 5'd5, 16'hBEEF, 8'h00, 8'h00);
    cyc();
    dbg(1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    expect_out("idle_after", 1'b0, 1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    cyc();

    // Merge: MEM flags-only with debug register-only
    mem(5'd0, 16'h5555, 8'h81, 8'h80);
    dbg(1'b1, 5'd3, 16'h1234, 8'h00, 8'h00);
    expect_out("merge_mflg", 1'b1, 1'b0, 5'd3, 16'h1234, 8'h81, 8'h80);
    cyc();
    // Merge: MEM register-only with debug flags-only
    mem(5'd6, 16'h6666, 8'h00, 8'h00);
    dbg(1'b1, 5'd0, 16'hDEAD, 8'h0F, 8'h05);
    expect_out("merge_mreg", 1'b1, 1'b0, 5'd6, 16'h6666, 8'h0F, 8'h05);
    cyc();
    mem(5'd0, 16'h0, 8'h0, 8'h0);
    dbg(1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    expect_out("merge_after", 1'b0, 1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    cyc();

    // Back-to-back debug writes with idle MEM
    dbg(1'b1, 5'd1, 16'h1111, 8'h00, 8'h00);
    expect_out("b2b_first", 1'b1, 1'b0, 5'd1, 16'h1111, 8'h00, 8'h00);
    cyc();
    dbg(1'b1, 5'd2, 16'h2222, 8'h02, 8'h01);
    expect_out("b2b_second", 1'b1, 1'b0, 5'd2, 16'h2222, 8'h02, 8'h01);
    cyc();

    // Null debug write
    dbg(1'b1, 5'd0, 16'hABCD, 8'h00, 8'h00);
    expect_out("null_write", 1'b1, 1'b0, 5'd0, 16'hABCD, 8'h00, 8'h00);
    cyc();

    // Conflict: MEM writes reg and flags, debug wants flags -> no merge
    mem(5'd2, 16'h0202, 8'h01, 8'h01);
    dbg(1'b1, 5'd0, 16'h0, 8'hF0, 8'hA0);
    expect_out("conflict_1", 1'b0, 1'b0, 5'd2, 16'h0202, 8'h01, 8'h01);
    cyc();
    expect_out("conflict_2", 1'b0, 1'b0, 5'd2, 16'h0202, 8'h01, 8'h01);
    cyc();
    dbg(1'b0, 5'd0, 16'h0, 8'hF0, 8'hA0);
    expect_out("conflict_drop", 1'b0, 1'b0, 5'd2, 16'h0202, 8'h01, 8'h01);
    cyc();

    // Starvation: ack forced on cycle 8 by a stolen MEM cycle
    mem(5'd7, 16'h7777, 8'h00, 8'h00);
    dbg(1'b1, 5'd4, 16'h4444, 8'h00, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      expect_out($sformatf("starve_c%0d", i), 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
      cyc();
    end
    expect_out("starve_steal", 1'b1, 1'b1, 5'd4, 16'h4444, 8'h00, 8'h00);
    cyc();
    dbg(1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    expect_out("starve_replay", 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
    cyc();

    // Reset mid-wait (counter at 5), then full MAX_WAIT wait again
    dbg(1'b1, 5'd4, 16'h4444, 8'h00, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      expect_out($sformatf("prerst_c%0d", i), 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
      cyc();
    end
    expect_out("rst_async", 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
    #1 rst = 1'b1;
    #1 sample();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      expect_out($sformatf("postrst_c%0d", i), 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
      cyc();
    end
    // Steal cycle, then reset asserted inside it must clear hold at once
    expect_out("postrst_steal", 1'b1, 1'b1, 5'd4, 16'h4444, 8'h00, 8'h00);
    @(negedge clk);
    sample();
    #1 rst = 1'b1;
    expect_out("rst_in_steal", 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
    #1 sample();
    @(posedge clk);
    #1 rst = 1'b0;
    dbg(1'b0, 5'd0, 16'h0, 8'h0, 8'h0);
    expect_out("final", 1'b0, 1'b0, 5'd7, 16'h7777, 8'h00, 8'h00);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
